// File: rtl/cp0_intc.sv
// MIPS CP0: mfc0/mtc0 register file, exception/interrupt arbitration and trap-entry capture.
// Optional Count/Compare timer is compiled in when CP0_TIMER_EN is defined.
module cp0_intc #(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] PRID      = 32'h0059756e,
    parameter int          COUNT_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wen,
    input  logic [4:0]           sel,
    input  logic [31:0]          din,
    output logic [31:0]          dout,
    input  logic [29:0]          pc,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 exc_req,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          bad_vaddr,
    input  logic                 eret,
    output logic                 trap,
    output logic [29:0]          epc
);
    logic [5:0]  hw_ext;
    logic [5:0]  iphw_q;
    logic [1:0]  ipsw_q, ipsw_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [29:0] epc_q, epc_d;
    logic [31:0] badva_q, badva_d;
    logic [7:0]  ip;
    logic        ti;
    logic        int_pend;
    logic        wr_ok;

    always_comb begin
        hw_ext = '0;
        hw_ext[NUM_HWINT-1:0] = hw_int;
    end

    assign wr_ok = wen & ~trap;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic [7:0]  presc_q, presc_d;
    logic        inc;

    assign ti = ti_q;

    always_comb begin
        inc       = (presc_q == 8'(COUNT_DIV - 1));
        presc_d   = inc ? 8'd0 : presc_q + 8'd1;
        count_d   = inc ? count_q + 32'd1 : count_q;
        ti_d      = ti_q | (inc & ((count_q + 32'd1) == compare_q));
        compare_d = compare_q;
        // A Count write overrides the increment and cannot raise TI that cycle.
        if (wr_ok && sel == 5'd9) begin
            count_d = din;
            presc_d = 8'd0;
            ti_d    = ti_q;
        end
        if (wr_ok && sel == 5'd11) begin
            compare_d = din;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            ti_q      <= 1'b0;
            presc_q   <= '0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
            presc_q   <= presc_d;
        end
    end
`else
    assign ti = 1'b0;
`endif

    always_comb begin
        ip    = {iphw_q, ipsw_q};
        ip[7] = iphw_q[5] | ti;
    end

    assign int_pend = (|(ip & im_q)) & ie_q & ~exl_q;
    assign trap     = (exc_req | int_pend) & ~exl_q;
    assign epc      = epc_q;

    always_comb begin
        ipsw_d    = ipsw_q;
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        badva_d   = badva_q;
        if (trap) begin
            // Trap entry swallows any same-cycle mtc0 or eret.
            exl_d     = 1'b1;
            epc_d     = pc;
            exccode_d = exc_req ? exc_code : 5'd0;
            if (exc_req && (exc_code == 5'd4 || exc_code == 5'd5))
                badva_d = bad_vaddr;
        end else begin
            if (wen) begin
                case (sel)
                    5'd12: begin
                        im_d  = din[15:8];
                        exl_d = din[1];
                        ie_d  = din[0];
                    end
                    5'd13:   ipsw_d = din[9:8];
                    5'd14:   epc_d  = din[31:2];
                    default: ;
                endcase
            end
            if (eret)
                exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iphw_q    <= '0;
            ipsw_q    <= '0;
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            exccode_q <= '0;
            epc_q     <= '0;
            badva_q   <= '0;
        end else begin
            iphw_q    <= hw_ext;
            ipsw_q    <= ipsw_d;
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
            badva_q   <= badva_d;
        end
    end

    always_comb begin
        dout = 32'd0;
        case (sel)
            5'd8:  dout = badva_q;
`ifdef CP0_TIMER_EN
            5'd9:  dout = count_q;
            5'd11: dout = compare_q;
`endif
            5'd12: dout = {16'b0, im_q, 6'b0, exl_q, ie_q};
            5'd13: dout = {1'b0, ti, 14'b0, ip, 1'b0, exccode_q, 2'b0};
            5'd14: dout = {epc_q, 2'b00};
            5'd15: dout = PRID;
            default: dout = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_cp0_intc.sv
// Scoreboard bench for cp0_intc: stimulus queues expected values, a negedge monitor compares them.
module tb_cp0_intc;
    localparam int KD = 0, KT = 1, KE = 2;

    logic        clk, rst, wen, exc_req, eret;
    logic [4:0]  sel, exc_code;
    logic [31:0] din, dout, bad_vaddr;
    logic [29:0] pc, epc;
    logic [5:0]  hw_int;
    logic        trap;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    cp0_intc dut (
        .clk(clk), .rst(rst), .wen(wen), .sel(sel), .din(din), .dout(dout),
        .pc(pc), .hw_int(hw_int), .exc_req(exc_req), .exc_code(exc_code),
        .bad_vaddr(bad_vaddr), .eret(eret), .trap(trap), .epc(epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                KD:      act = dout;
                KT:      act = {31'b0, trap};
                default: act = {2'b0, epc};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
            end
        end
    end

    task automatic push(input string n, input int k, input logic [31:0] e);
        exp_t x;
        x.name = n; x.kind = k; x.exp = e;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        wen = 1'b0; eret = 1'b0; exc_req = 1'b0;
    endtask

    task automatic wr(input logic [4:0] s, input logic [31:0] d);
        sel = s; din = d; wen = 1'b1;
        step();
    endtask

    task automatic rd(input string n, input logic [4:0] s, input logic [31:0] e);
        sel = s; wen = 1'b0;
        push(n, KD, e);
        step();
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; sel = '0; din = '0; pc = '0; hw_int = '0;
        exc_req = 1'b0; exc_code = '0; bad_vaddr = '0; eret = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push("rst_trap", KT, 32'd0);
        push("rst_epc", KE, 32'd0);
        rd("rst_sr", 5'd12, 32'd0);
        rd("rst_prid", 5'd15, 32'h0059756e);
`ifdef CP0_TIMER_EN
        rd("rst_compare", 5'd11, 32'hFFFF_FFFF);
`else
        rd("rst_compare", 5'd11, 32'd0);
`endif
        rst = 1'b0;
        step();

        // Hardware interrupt 0 with IM[2], IE.
        pc = 30'h100; hw_int = 6'b000001;
        wr(5'd12, 32'h0000_0401);
        push("hw_trap", KT, 32'd1);
        rd("hw_sr_pre", 5'd12, 32'h0000_0401);
        push("hw_trap_exl", KT, 32'd0);
        push("hw_epc", KE, 32'h100);
        rd("hw_sr_post", 5'd12, 32'h0000_0403);
        rd("hw_cause", 5'd13, 32'h0000_0400);
        hw_int = '0; eret = 1'b1;
        step();
        push("hw_after_eret", KT, 32'd0);
        wr(5'd12, 32'h0);

        // Exception beats same-cycle interrupt; no retrap while EXL.
        hw_int = 6'b000001;
        wr(5'd12, 32'h0000_0401);
        pc = 30'h200; exc_req = 1'b1; exc_code = 5'd5; bad_vaddr = 32'h1000_0003;
        push("exc_trap", KT, 32'd1);
        step();
        push("exc_epc", KE, 32'h200);
        rd("exc_cause", 5'd13, 32'h0000_0414);
        rd("exc_badva", 5'd8, 32'h1000_0003);
        exc_req = 1'b1; exc_code = 5'd4; bad_vaddr = 32'h0000_DEAD; pc = 30'h250;
        push("exc_exl_notrap", KT, 32'd0);
        step();
        rd("exc_badva_kept", 5'd8, 32'h1000_0003);
        push("exc_epc_kept", KE, 32'h200);
        rd("exc_cause_kept", 5'd13, 32'h0000_0414);
        eret = 1'b1;
        step();
        pc = 30'h300;
        push("eret_int_trap", KT, 32'd1);
        step();
        push("eret_int_epc", KE, 32'h300);
        rd("eret_int_cause", 5'd13, 32'h0000_0400);
        hw_int = '0; eret = 1'b1;
        step();
        wr(5'd12, 32'h0);

        // Software interrupt; mtc0 during trap cycle is dropped.
        wr(5'd12, 32'h0000_0101);
        push("sw_no_trap", KT, 32'd0);
        wr(5'd13, 32'h0000_0100);
        push("sw_trap", KT, 32'd1);
        pc = 30'h350;
        wr(5'd13, 32'h0);
        rd("sw_cause_kept", 5'd13, 32'h0000_0100);
        wr(5'd13, 32'h0);
        rd("sw_cause_clr", 5'd13, 32'h0);
        eret = 1'b1;
        step();
        push("sw_cleared", KT, 32'd0);
        rd("sw_sr", 5'd12, 32'h0000_0101);

        // Trap with same-cycle mtc0 SR and eret.
        wr(5'd13, 32'h0000_0100);
        pc = 30'h400; eret = 1'b1;
        wr(5'd12, 32'h0000_FF01);
        rd("tme_sr", 5'd12, 32'h0000_0103);
        push("tme_epc", KE, 32'h400);
        wr(5'd13, 32'h0);
        eret = 1'b1;
        wr(5'd12, 32'h0000_0003);
        rd("eret_mtc0_sr", 5'd12, 32'h0000_0001);
        wr(5'd12, 32'h0);

        // Unmapped/read-only registers, EPC write.
        wr(5'd8, 32'h5555_5555);
        rd("badva_ro", 5'd8, 32'h1000_0003);
        rd("unmapped", 5'd20, 32'h0);
        wr(5'd14, 32'h1234_5677);
        rd("epc_rd", 5'd14, 32'h1234_5674);
        push("epc_port", KE, 32'h048D_159D);

`ifdef CP0_TIMER_EN
        wr(5'd12, 32'h0000_8001);
        wr(5'd11, 32'd12);
        wr(5'd9, 32'd10);
        pc = 30'h500;
        rd("cnt_10", 5'd9, 32'd10);
        rd("cause_no_ti", 5'd13, 32'h0);
        push("ti_trap", KT, 32'd1);
        rd("cause_ti", 5'd13, 32'h4000_8000);
        push("ti_epc", KE, 32'h500);
        rd("ti_sr", 5'd12, 32'h0000_8003);
        wr(5'd11, 32'hFFFF_FFFF);
        rd("ti_clr", 5'd13, 32'h0);
        wr(5'd9, 32'hFFFF_FFFF);
        rd("cnt_max", 5'd9, 32'hFFFF_FFFF);
        rd("cnt_wrap", 5'd9, 32'h0);
        eret = 1'b1;
        step();
        wr(5'd12, 32'h0);
`else
        rd("no_count", 5'd9, 32'h0);
        rd("no_compare", 5'd11, 32'h0);
`endif

        // Asynchronous reset mid-run with EXL=1 and IM=FF.
        hw_int = 6'b000001;
        wr(5'd12, 32'h0000_FF03);
        rd("pre_rst_sr", 5'd12, 32'h0000_FF03);
        #2 rst = 1'b1;
        sel = 5'd12;
        push("arst_trap", KT, 32'd0);
        push("arst_epc", KE, 32'd0);
        push("arst_sr", KD, 32'd0);
        step();
        rd("arst_cause", 5'd13, 32'h0);
        rst = 1'b0;
        rd("post_rst_sr", 5'd12, 32'h0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
